fpu_issue_ctrl: RTL and testbench

- Multi-cycle issue/sequencing controller for the FPU register file and float add/sub/mult datapath.
- Accepts one FP-class instruction at a time from the CPU via valid/ready, drives register-file addresses and ALU function select, and holds operands stable for a per-op latency.
- Issues exactly one writeback (arith, lwc1) or one memory write strobe (swc1), then reports completion.
- Sits between the main decoder and the FPU datapath; replaces the single-cycle combinational select.

---
 rtl/fpu_ctrl_pkg.sv | 59 +++++
 rtl/fpu_exec_timer.sv | 40 ++++
 rtl/fpu_issue_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ctrl_pkg.sv
// Shared encodings for the FPU issue controller: op kinds, funct codes,
// ALU selects, FSM states and instruction field positions.
package fpu_ctrl_pkg;

   // op_kind encodings presented by the main decoder
   localparam logic [1:0] OP_ARITH = 2'b00;
   localparam logic [1:0] OP_LWC1  = 2'b01;
   localparam logic [1:0] OP_SWC1  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   // arithmetic funct codes
   localparam logic [5:0] FUNCT_ADD = 6'd0;
   localparam logic [5:0] FUNCT_SUB = 6'd1;
   localparam logic [5:0] FUNCT_MUL = 6'd2;

   // alu_func encodings driven to the datapath
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_MUL = 2'b10;

   // instruction field bit positions
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int FS_MSB    = 15;
   localparam int FS_LSB    = 11;
   localparam int FD_MSB    = 10;
   localparam int FD_LSB    = 6;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

   // execution timer width
   localparam int TIMER_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_EXEC  = 2'b01,
      ST_WB    = 2'b10,
      ST_STORE = 2'b11
   } state_t;

   // Map an arithmetic funct code onto the ALU select; illegal codes never
   // reach the datapath, so they fall back to add.
   function automatic logic [1:0] funct_to_alu(input logic [5:0] funct);
      logic [1:0] alu;
      case (funct)
         FUNCT_ADD: alu = ALU_ADD;
         FUNCT_SUB: alu = ALU_SUB;
         FUNCT_MUL: alu = ALU_MUL;
         default:   alu = ALU_ADD;
      endcase
      return alu;
   endfunction

   // Only add, sub and mult are implemented.
   function automatic logic funct_is_legal(input logic [5:0] funct);
      return (funct <= FUNCT_MUL);
   endfunction

endpackage

// File: rtl/fpu_exec_timer.sv
// Loadable down-counter that measures the EXEC phase of an FPU op.
// Stops at zero; the zero flag tells the controller EXEC is finishing.
module fpu_exec_timer
   import fpu_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               dec,
   output logic               zero
);

   logic [TIMER_W-1:0] cnt_q;
   logic [TIMER_W-1:0] cnt_d;

   // Next count: load wins over decrement, decrement saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != {TIMER_W{1'b0}})) begin
         cnt_d = cnt_q - {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= {TIMER_W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == {TIMER_W{1'b0}});

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Multi-cycle issue/sequencing controller for the FPU register file and
// add/sub/mult datapath. Accepts one instruction in IDLE, holds operands
// for the op latency, then emits a single writeback or store strobe.
module fpu_issue_ctrl
   import fpu_ctrl_pkg::*;
#(
   parameter int ADD_LAT = 2,
   parameter int MUL_LAT = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instruction,
   input  logic [1:0]  op_kind,
   output logic [4:0]  rf_raddr1,
   output logic [4:0]  rf_raddr2,
   output logic [4:0]  rf_waddr,
   output logic        rf_we,
   output logic        rf_wsel,
   output logic [1:0]  alu_func,
   output logic        mem_we,
   output logic        op_done,
   output logic        illegal_op
);

   // Latencies must fit the 4-bit timer and be at least one EXEC cycle.
   if ((ADD_LAT < 1) || (ADD_LAT > 15)) begin : g_bad_add_lat
      $error("fpu_issue_ctrl: ADD_LAT must be within 1..15");
   end
   if ((MUL_LAT < 1) || (MUL_LAT > 15)) begin : g_bad_mul_lat
      $error("fpu_issue_ctrl: MUL_LAT must be within 1..15");
   end

   localparam logic [TIMER_W-1:0] ADD_LOAD = TIMER_W'(ADD_LAT - 1);
   localparam logic [TIMER_W-1:0] MUL_LOAD = TIMER_W'(MUL_LAT - 1);

   // FSM state and captured instruction fields
   state_t      state_q, state_d;
   logic [1:0]  kind_q, kind_d;
   logic [4:0]  rt_q, rt_d;
   logic [4:0]  fs_q, fs_d;
   logic [4:0]  fd_q, fd_d;
   logic [1:0]  alu_sel_q, alu_sel_d;

   // registered outputs
   logic [4:0]  rf_raddr1_q, rf_raddr1_d;
   logic [4:0]  rf_raddr2_q, rf_raddr2_d;
   logic [4:0]  rf_waddr_q, rf_waddr_d;
   logic        rf_we_q, rf_we_d;
   logic        rf_wsel_q, rf_wsel_d;
   logic [1:0]  alu_func_q, alu_func_d;
   logic        mem_we_q, mem_we_d;
   logic        op_done_q, op_done_d;
   logic        illegal_op_q, illegal_op_d;

   // timer interface
   logic               timer_load;
   logic [TIMER_W-1:0] timer_load_val;
   logic               timer_dec;
   logic               timer_zero;

   // decoded instruction fields
   logic [4:0]  in_rt;
   logic [4:0]  in_fs;
   logic [4:0]  in_fd;
   logic [5:0]  in_funct;
   logic        accept;
   logic        unused_instr_bits;

   assign in_rt    = instruction[RT_MSB:RT_LSB];
   assign in_fs    = instruction[FS_MSB:FS_LSB];
   assign in_fd    = instruction[FD_MSB:FD_LSB];
   assign in_funct = instruction[FUNCT_MSB:FUNCT_LSB];
   assign unused_instr_bits = ^instruction[31:21];

   assign accept      = instr_valid && (state_q == ST_IDLE);
   assign instr_ready = (state_q == ST_IDLE);
   assign timer_dec   = (state_q == ST_EXEC);

   fpu_exec_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_load_val),
      .dec      (timer_dec),
      .zero     (timer_zero)
   );

   // Next-state logic: capture fields at accept and sequence the op.
   always_comb begin
      state_d        = state_q;
      kind_d         = kind_q;
      rt_d           = rt_q;
      fs_d           = fs_q;
      fd_d           = fd_q;
      alu_sel_d      = alu_sel_q;
      illegal_op_d   = 1'b0;
      timer_load     = 1'b0;
      timer_load_val = {TIMER_W{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               kind_d    = op_kind;
               rt_d      = in_rt;
               fs_d      = in_fs;
               fd_d      = in_fd;
               alu_sel_d = funct_to_alu(in_funct);
               case (op_kind)
                  OP_ARITH: begin
                     if (funct_is_legal(in_funct)) begin
                        state_d        = ST_EXEC;
                        timer_load     = 1'b1;
                        timer_load_val = (in_funct == FUNCT_MUL) ? MUL_LOAD : ADD_LOAD;
                     end else begin
                        illegal_op_d = 1'b1;
                     end
                  end
                  OP_LWC1: state_d      = ST_WB;
                  OP_SWC1: state_d      = ST_STORE;
                  OP_RSVD: illegal_op_d = 1'b1;
                  default: illegal_op_d = 1'b1;
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (timer_zero) begin
               state_d = ST_WB;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_WB:    state_d = ST_IDLE;
         ST_STORE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode from the next state so every output is a flop aligned
   // with the state it describes.
   always_comb begin
      rf_raddr1_d = 5'd0;
      rf_raddr2_d = 5'd0;
      rf_waddr_d  = 5'd0;
      rf_we_d     = 1'b0;
      rf_wsel_d   = 1'b0;
      alu_func_d  = 2'b00;
      mem_we_d    = 1'b0;
      op_done_d   = 1'b0;
      case (state_d)
         ST_EXEC: begin
            rf_raddr1_d = fs_d;
            rf_raddr2_d = rt_d;
            alu_func_d  = alu_sel_d;
         end
         ST_WB: begin
            op_done_d = 1'b1;
            if (kind_d == OP_ARITH) begin
               rf_raddr1_d = fs_d;
               rf_raddr2_d = rt_d;
               alu_func_d  = alu_sel_d;
               rf_waddr_d  = fd_d;
               rf_wsel_d   = 1'b0;
               rf_we_d     = (fd_d != 5'd0);
            end else begin
               rf_waddr_d  = rt_d;
               rf_wsel_d   = 1'b1;
               rf_we_d     = (rt_d != 5'd0);
            end
         end
         ST_STORE: begin
            rf_raddr1_d = rt_d;
            mem_we_d    = 1'b1;
            op_done_d   = 1'b1;
         end
         default: begin
            rf_raddr1_d = 5'd0;
         end
      endcase
   end

   // State, captured fields and output registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         kind_q       <= 2'b00;
         rt_q         <= 5'd0;
         fs_q         <= 5'd0;
         fd_q         <= 5'd0;
         alu_sel_q    <= 2'b00;
         rf_raddr1_q  <= 5'd0;
         rf_raddr2_q  <= 5'd0;
         rf_waddr_q   <= 5'd0;
         rf_we_q      <= 1'b0;
         rf_wsel_q    <= 1'b0;
         alu_func_q   <= 2'b00;
         mem_we_q     <= 1'b0;
         op_done_q    <= 1'b0;
         illegal_op_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         kind_q       <= kind_d;
         rt_q         <= rt_d;
         fs_q         <= fs_d;
         fd_q         <= fd_d;
         alu_sel_q    <= alu_sel_d;
         rf_raddr1_q  <= rf_raddr1_d;
         rf_raddr2_q  <= rf_raddr2_d;
         rf_waddr_q   <= rf_waddr_d;
         rf_we_q      <= rf_we_d;
         rf_wsel_q    <= rf_wsel_d;
         alu_func_q   <= alu_func_d;
         mem_we_q     <= mem_we_d;
         op_done_q    <= op_done_d;
         illegal_op_q <= illegal_op_d;
      end
   end

   assign rf_raddr1  = rf_raddr1_q;
   assign rf_raddr2  = rf_raddr2_q;
   assign rf_waddr   = rf_waddr_q;
   assign rf_we      = rf_we_q;
   assign rf_wsel    = rf_wsel_q;
   assign alu_func   = alu_func_q;
   assign mem_we     = mem_we_q;
   assign op_done    = op_done_q;
   assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: the driver computes each op's
// expected retirement from the op rules, a monitor compares on every pulse.
module tb_fpu_issue_ctrl;

   localparam int ADD_LAT = 2;
   localparam int MUL_LAT = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic [31:0] instruction = 32'd0;
   logic [1:0]  op_kind = 2'b00;
   logic        instr_ready;
   logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
   logic        rf_we, rf_wsel, mem_we, op_done, illegal_op;
   logic [1:0]  alu_func;

   fpu_issue_ctrl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .op_kind(op_kind), .rf_raddr1(rf_raddr1),
      .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we), .rf_wsel(rf_wsel),
      .alu_func(alu_func), .mem_we(mem_we), .op_done(op_done), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   // edge counter: value seen between edges is the number of the last edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   typedef struct {
      int         cyc;
      bit         illegal;
      bit         we;
      logic [4:0] waddr;
      bit         wsel;
      bit         mwe;
   } exp_t;
   exp_t sb[$];

   // expected read-port window of the op in flight
   int         win_start = -1;
   int         win_end = -1;
   logic [4:0] win_r1 = 5'd0, win_r2 = 5'd0;
   logic [1:0] win_alu = 2'b00;
   int         free_at = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] funct, input logic [4:0] fd,
                                      input logic [4:0] fs, input logic [4:0] rt);
      logic [31:0] w;
      w = $urandom;
      w[20:16] = rt;
      w[15:11] = fs;
      w[10:6]  = fd;
      w[5:0]   = funct;
      return w;
   endfunction

   // Reference model: expected effect of an op accepted on the coming edge.
   task automatic model_accept(input logic [1:0] k, input logic [31:0] ins);
      exp_t e;
      int t, lat, funct;
      logic [4:0] rt, fs, fd;
      t = cyc + 1;
      funct = int'(ins[5:0]);
      rt = ins[20:16]; fs = ins[15:11]; fd = ins[10:6];
      e = '{cyc: t, illegal: 1'b0, we: 1'b0, waddr: 5'd0, wsel: 1'b0, mwe: 1'b0};
      if (k == 2'd3 || (k == 2'd0 && funct > 2)) begin
         e.illegal = 1'b1;
         free_at = t;
      end else if (k == 2'd0) begin
         lat = (funct == 2) ? MUL_LAT : ADD_LAT;
         e.cyc = t + lat;
         e.we = (fd != 5'd0);
         e.waddr = fd;
         win_start = t; win_end = t + lat;
         win_r1 = fs; win_r2 = rt;
         win_alu = (funct == 0) ? 2'b00 : (funct == 1) ? 2'b01 : 2'b10;
         free_at = t + lat + 1;
      end else if (k == 2'd1) begin
         e.we = (rt != 5'd0);
         e.waddr = rt;
         e.wsel = 1'b1;
         win_start = t; win_end = t;
         win_r1 = 5'd0; win_r2 = 5'd0; win_alu = 2'b00;
         free_at = t + 1;
      end else begin
         e.mwe = 1'b1;
         win_start = t; win_end = t;
         win_r1 = rt; win_r2 = 5'd0; win_alu = 2'b00;
         free_at = t + 1;
      end
      sb.push_back(e);
   endtask

   // Advance to mid-cycle and compare instr_ready against the model.
   task automatic tick();
      @(negedge clk);
      #1;
      check("instr_ready", instr_ready, (cyc >= free_at) ? 32'd1 : 32'd0);
   endtask

   task automatic issue(input logic [1:0] k, input logic [31:0] ins);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         tick();
         instr_valid = 1'b1;
         op_kind = k;
         instruction = ins;
         if (cyc >= free_at) begin
            model_accept(k, ins);
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout actual=busy expected=ready cyc=%0d", cyc);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         instr_valid = 1'b0;
         op_kind = 2'($urandom);
         instruction = $urandom;
      end
   endtask

   task automatic check_reset_outs();
      check("reset_outs", {rf_raddr1, rf_raddr2, rf_waddr, rf_we, rf_wsel, alu_func,
                           mem_we, op_done, illegal_op}, 32'd0);
      check("reset_ready", instr_ready, 32'd1);
   endtask

   // Monitor: read ports every cycle, retire pulses against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && !reset) begin
            if (cyc >= win_start && cyc <= win_end)
               check("rd_ports", {rf_raddr1, rf_raddr2, alu_func}, {win_r1, win_r2, win_alu});
            else
               check("rd_ports_idle", {rf_raddr1, rf_raddr2, alu_func}, 32'd0);
            if (op_done || illegal_op || rf_we || mem_we) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_retire actual=done%0b/ill%0b/we%0b/mwe%0b expected=none cyc=%0d",
                           op_done, illegal_op, rf_we, mem_we, cyc);
               end else begin
                  e = sb.pop_front();
                  check("retire_cyc", cyc, e.cyc);
                  check("illegal_op", illegal_op, {31'd0, e.illegal});
                  check("op_done", op_done, {31'd0, !e.illegal});
                  check("rf_we", rf_we, {31'd0, e.we});
                  check("rf_waddr", rf_waddr, {27'd0, e.waddr});
                  check("rf_wsel", rf_wsel, {31'd0, e.wsel});
                  check("mem_we", mem_we, {31'd0, e.mwe});
               end
            end else begin
               check("wb_idle", {rf_waddr, rf_wsel}, 32'd0);
               if (sb.size() > 0 && sb[0].cyc < cyc) begin
                  checks++; errors++;
                  $display("FAIL missing_retire actual=none expected_cyc=%0d cyc=%0d", sb[0].cyc, cyc);
                  void'(sb.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      logic [1:0] k;
      logic [5:0] f;
      #1 reset = 1'b1;
      #2 check_reset_outs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mon_en = 1'b1;
      free_at = 0;

      // directed cases
      issue(2'd0, mk(6'd0, 5'd3, 5'd1, 5'd2));     // add.s f3 = f1 + f2
      idle(1);
      issue(2'd0, mk(6'd2, 5'd4, 5'd2, 5'd2));     // mul.s f4 = f2 * f2
      issue(2'd1, mk(6'd0, 5'd0, 5'd0, 5'd7));     // lwc1 f7
      issue(2'd2, mk(6'd0, 5'd0, 5'd0, 5'd7));     // swc1 f7
      issue(2'd0, mk(6'h3F, 5'd5, 5'd6, 5'd7));    // illegal funct
      issue(2'd3, mk(6'd0, 5'd5, 5'd6, 5'd7));     // reserved op_kind
      issue(2'd0, mk(6'd0, 5'd0, 5'd1, 5'd2));     // add.s to f0
      issue(2'd0, mk(6'd1, 5'd9, 5'd8, 5'd6));     // sub.s back-to-back
      issue(2'd1, mk(6'd0, 5'd0, 5'd0, 5'd0));     // lwc1 to f0
      idle(3);

      // reset during EXEC cycle 2 of a mult
      issue(2'd0, mk(6'd2, 5'd5, 5'd3, 5'd4));
      t = cyc + 1;
      while (cyc < t + 1) tick();
      instr_valid = 1'b0;
      #1 reset = 1'b1;
      sb.delete();
      win_end = -1;
      free_at = 0;
      #1 check_reset_outs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      idle(2);

      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         k = 2'($urandom_range(0, 9) < 5 ? 0 : $urandom_range(1, 3));
         f = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(3, 63)) : 6'($urandom_range(0, 2));
         issue(k, mk(f, 5'($urandom), 5'($urandom), 5'($urandom)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      idle(12);
      check("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
